// File: rtl/memory.sv
// Memory-access pipeline stage: bus load/store sequencing and load-data alignment.
// Optional misaligned-access trap enabled by defining MISALIGN_CHECK_EN.
module memory #(
    parameter int XLEN      = 64,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 e_valid,
    input  logic [XLEN-1:0]      e_pc,
    input  logic [3:0]           e_mem_op,
    input  logic [XLEN-1:0]      e_addr,
    input  logic [XLEN-1:0]      e_wdata,
    input  logic [XLEN-1:0]      e_result,
    input  logic [REG_IDX_W-1:0] e_dst,
    input  logic                 e_regwrite,
    output logic                 stall_o,
    output logic                 dreq_valid,
    output logic [XLEN-1:0]      dreq_addr,
    output logic [2:0]           dreq_size,
    output logic [7:0]           dreq_strobe,
    output logic [XLEN-1:0]      dreq_data,
    input  logic                 dresp_addr_ok,
    input  logic                 dresp_data_ok,
    input  logic [XLEN-1:0]      dresp_data,
    output logic                 m_valid,
    output logic [XLEN-1:0]      m_pc,
    output logic [XLEN-1:0]      m_result,
    output logic [REG_IDX_W-1:0] m_dst,
    output logic                 m_regwrite
`ifdef MISALIGN_CHECK_EN
    ,
    output logic                 m_misalign
`endif
);

    localparam logic [3:0] OP_LB  = 4'h1;
    localparam logic [3:0] OP_LH  = 4'h2;
    localparam logic [3:0] OP_LW  = 4'h3;
    localparam logic [3:0] OP_LD  = 4'h4;
    localparam logic [3:0] OP_LBU = 4'h5;
    localparam logic [3:0] OP_LHU = 4'h6;
    localparam logic [3:0] OP_LWU = 4'h7;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;
    localparam logic [3:0] OP_SD  = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT_DATA
    } state_e;

    function automatic logic [1:0] size_of(input logic [3:0] op);
        logic [1:0] s;
        case (op)
            OP_LH, OP_LHU, OP_SH: s = 2'd1;
            OP_LW, OP_LWU, OP_SW: s = 2'd2;
            OP_LD, OP_SD:         s = 2'd3;
            default:              s = 2'd0;
        endcase
        return s;
    endfunction

    state_e                 state_q, state_d;
    logic [3:0]             op_q, op_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [REG_IDX_W-1:0]   dst_q, dst_d;
    logic                   rw_q, rw_d;

    logic                   m_valid_q, m_valid_d;
    logic [XLEN-1:0]        m_pc_q, m_pc_d;
    logic [XLEN-1:0]        m_result_q, m_result_d;
    logic [REG_IDX_W-1:0]   m_dst_q, m_dst_d;
    logic                   m_rw_q, m_rw_d;

    logic                   e_load_w, e_store_w;
    logic                   q_load_w, q_store_w;
    logic [1:0]             q_size_w;
    logic [7:0]             base_mask_w;
    logic [XLEN-1:0]        ld_sh_w, ld_ext_w;
    logic                   in_access_w;

    assign e_load_w  = (e_mem_op >= OP_LB) && (e_mem_op <= OP_LWU);
    assign e_store_w = (e_mem_op >= OP_SB) && (e_mem_op <= OP_SD);
    assign q_load_w  = (op_q >= OP_LB) && (op_q <= OP_LWU);
    assign q_store_w = (op_q >= OP_SB) && (op_q <= OP_SD);
    assign q_size_w  = size_of(op_q);

`ifdef MISALIGN_CHECK_EN
    logic                   mis_w;
    logic [2:0]             amask_w;
    logic                   m_mis_q, m_mis_d;

    always_comb begin
        case (size_of(e_mem_op))
            2'd1:    amask_w = 3'b001;
            2'd2:    amask_w = 3'b011;
            2'd3:    amask_w = 3'b111;
            default: amask_w = 3'b000;
        endcase
    end

    assign mis_w      = (e_load_w || e_store_w) && |(e_addr[2:0] & amask_w);
    assign m_misalign = m_mis_q;
`endif

    always_comb begin
        case (q_size_w)
            2'd0:    base_mask_w = 8'h01;
            2'd1:    base_mask_w = 8'h03;
            2'd2:    base_mask_w = 8'h0F;
            default: base_mask_w = 8'hFF;
        endcase
    end

    // Lane select first, then extend; upper lanes shifted out read as zero.
    assign ld_sh_w = dresp_data >> {addr_q[2:0], 3'b000};

    always_comb begin
        case (op_q)
            OP_LB:   ld_ext_w = {{(XLEN-8){ld_sh_w[7]}}, ld_sh_w[7:0]};
            OP_LH:   ld_ext_w = {{(XLEN-16){ld_sh_w[15]}}, ld_sh_w[15:0]};
            OP_LW:   ld_ext_w = {{(XLEN-32){ld_sh_w[31]}}, ld_sh_w[31:0]};
            OP_LBU:  ld_ext_w = {{(XLEN-8){1'b0}}, ld_sh_w[7:0]};
            OP_LHU:  ld_ext_w = {{(XLEN-16){1'b0}}, ld_sh_w[15:0]};
            OP_LWU:  ld_ext_w = {{(XLEN-32){1'b0}}, ld_sh_w[31:0]};
            default: ld_ext_w = ld_sh_w;
        endcase
    end

    assign in_access_w = (state_q == ACCESS);
    assign stall_o     = (state_q != IDLE);
    assign dreq_valid  = in_access_w;
    assign dreq_addr   = in_access_w ? addr_q : '0;
    assign dreq_size   = in_access_w ? {1'b0, q_size_w} : 3'd0;
    assign dreq_strobe = (in_access_w && q_store_w) ?
                         (base_mask_w << addr_q[2:0]) : 8'h00;
    assign dreq_data   = (in_access_w && q_store_w) ?
                         (wdata_q << {addr_q[2:0], 3'b000}) : '0;

    assign m_valid    = m_valid_q;
    assign m_pc       = m_pc_q;
    assign m_result   = m_result_q;
    assign m_dst      = m_dst_q;
    assign m_regwrite = m_rw_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        dst_d      = dst_q;
        rw_d       = rw_q;
        m_valid_d  = 1'b0;
        m_pc_d     = m_pc_q;
        m_result_d = m_result_q;
        m_dst_d    = m_dst_q;
        m_rw_d     = 1'b0;
`ifdef MISALIGN_CHECK_EN
        m_mis_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (e_valid) begin
                    if (!(e_load_w || e_store_w)) begin
                        m_valid_d  = 1'b1;
                        m_pc_d     = e_pc;
                        m_result_d = e_result;
                        m_dst_d    = e_dst;
                        m_rw_d     = e_regwrite;
`ifdef MISALIGN_CHECK_EN
                    end else if (mis_w) begin
                        m_valid_d  = 1'b1;
                        m_pc_d     = e_pc;
                        m_result_d = e_addr;
                        m_dst_d    = e_dst;
                        m_mis_d    = 1'b1;
`endif
                    end else begin
                        op_d    = e_mem_op;
                        addr_d  = e_addr;
                        wdata_d = e_wdata;
                        pc_d    = e_pc;
                        dst_d   = e_dst;
                        rw_d    = e_regwrite;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dresp_addr_ok) begin
                    state_d = dresp_data_ok ? IDLE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (dresp_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Retire the captured access on the edge that leaves the bus states.
        if (state_q != IDLE && state_d == IDLE) begin
            m_valid_d  = 1'b1;
            m_pc_d     = pc_q;
            m_dst_d    = dst_q;
            m_result_d = q_load_w ? ld_ext_w : '0;
            m_rw_d     = q_load_w && rw_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pc_q       <= '0;
            dst_q      <= '0;
            rw_q       <= 1'b0;
            m_valid_q  <= 1'b0;
            m_pc_q     <= '0;
            m_result_q <= '0;
            m_dst_q    <= '0;
            m_rw_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            dst_q      <= dst_d;
            rw_q       <= rw_d;
            m_valid_q  <= m_valid_d;
            m_pc_q     <= m_pc_d;
            m_result_q <= m_result_d;
            m_dst_q    <= m_dst_d;
            m_rw_q     <= m_rw_d;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            m_mis_q <= 1'b0;
        end else begin
            m_mis_q <= m_mis_d;
        end
    end
`endif

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage: vector table, corner sequences,
// and random instructions against a byte-lane reference model.
module tb_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [3:0]  e_mem_op;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [63:0] e_result;
    logic [4:0]  e_dst;
    logic        e_regwrite;
    logic        stall_o;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        m_valid;
    logic [63:0] m_pc;
    logic [63:0] m_result;
    logic [4:0]  m_dst;
    logic        m_regwrite;
`ifdef MISALIGN_CHECK_EN
    logic        m_misalign;
`endif

    always #5 clk = ~clk;

    memory dut (
        .clk          (clk),
        .reset        (reset),
        .e_valid      (e_valid),
        .e_pc         (e_pc),
        .e_mem_op     (e_mem_op),
        .e_addr       (e_addr),
        .e_wdata      (e_wdata),
        .e_result     (e_result),
        .e_dst        (e_dst),
        .e_regwrite   (e_regwrite),
        .stall_o      (stall_o),
        .dreq_valid   (dreq_valid),
        .dreq_addr    (dreq_addr),
        .dreq_size    (dreq_size),
        .dreq_strobe  (dreq_strobe),
        .dreq_data    (dreq_data),
        .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data   (dresp_data),
        .m_valid      (m_valid),
        .m_pc         (m_pc),
        .m_result     (m_result),
        .m_dst        (m_dst),
`ifdef MISALIGN_CHECK_EN
        .m_regwrite   (m_regwrite),
        .m_misalign   (m_misalign)
`else
        .m_regwrite   (m_regwrite)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: byte-lane view of the access.
    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'h1, 4'h5, 4'h8: return 1;
            4'h2, 4'h6, 4'h9: return 2;
            4'h3, 4'h7, 4'hA: return 4;
            4'h4, 4'hB:       return 8;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [63:0] mdl_load(input logic [3:0] op,
                                             input logic [63:0] addr,
                                             input logic [63:0] rd);
        int n = op_bytes(op);
        int off = int'(addr[2:0]);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (op inside {4'h1, 4'h2, 4'h3} && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] mdl_strobe(input int n, input int off);
        logic [7:0] s = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] mdl_sdata(input logic [63:0] wd,
                                              input int off);
        logic [63:0] d = '0;
        for (int j = 0; j < 8; j++)
            if (j >= off) d[8*j +: 8] = wd[8*(j-off) +: 8];
        return d;
    endfunction

    function automatic logic [2:0] mdl_size(input int n);
        case (n)
            2:       return 3'd1;
            4:       return 3'd2;
            8:       return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    // Entry and exit on a falling edge; the completing falling edge is
    // where the next instruction may be presented.
    task automatic run_instr(
        input logic [3:0]  op,    input logic [63:0] pc,
        input logic [63:0] addr,  input logic [63:0] wdata,
        input logic [63:0] result, input logic [4:0] dst,
        input logic        rw,    input int a_dly, input int d_dly,
        input logic [63:0] rdata, input logic [63:0] exp_res,
        input logic        exp_rw, input logic [2:0] exp_size,
        input logic [7:0]  exp_strb, input logic [63:0] exp_data,
        input logic        exp_mis);
        bit mem, st;
        mem = (op_bytes(op) != 0);
        st  = (op inside {[4'h8:4'hB]});
        e_valid    = 1'b1;
        e_mem_op   = op;
        e_pc       = pc;
        e_addr     = addr;
        e_wdata    = wdata;
        e_result   = result;
        e_dst      = dst;
        e_regwrite = rw;
        chk("stall_at_accept", 64'(stall_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        e_valid  = 1'b0;
        e_mem_op = 4'h0;
        if (mem && !exp_mis) begin
            for (int k = 0; k <= a_dly; k++) begin
                chk("access_dreq_valid", 64'(dreq_valid), 64'd1);
                chk("access_stall", 64'(stall_o), 64'd1);
                chk("access_m_valid", 64'(m_valid), 64'd0);
                chk("dreq_addr", dreq_addr, addr);
                chk("dreq_size", 64'(dreq_size), 64'(exp_size));
                chk("dreq_strobe", 64'(dreq_strobe), 64'(exp_strb));
                if (st) chk("dreq_data", dreq_data, exp_data);
                if (k == a_dly) begin
                    dresp_addr_ok = 1'b1;
                    if (d_dly == 0) begin
                        dresp_data_ok = 1'b1;
                        dresp_data    = rdata;
                    end
                end
                @(posedge clk);
                @(negedge clk);
                dresp_addr_ok = 1'b0;
                dresp_data_ok = 1'b0;
                dresp_data    = ~rdata;
            end
            for (int j = 1; j <= d_dly; j++) begin
                chk("wait_dreq_valid", 64'(dreq_valid), 64'd0);
                chk("wait_stall", 64'(stall_o), 64'd1);
                chk("wait_m_valid", 64'(m_valid), 64'd0);
                if (j == d_dly) begin
                    dresp_data_ok = 1'b1;
                    dresp_data    = rdata;
                end
                @(posedge clk);
                @(negedge clk);
                dresp_data_ok = 1'b0;
                dresp_data    = ~rdata;
            end
        end else begin
            chk("single_dreq_valid", 64'(dreq_valid), 64'd0);
        end
        chk("retire_m_valid", 64'(m_valid), 64'd1);
        chk("retire_m_pc", m_pc, pc);
        chk("retire_m_result", m_result, exp_res);
        chk("retire_m_dst", 64'(m_dst), 64'(dst));
        chk("retire_m_regwrite", 64'(m_regwrite), 64'(exp_rw));
        chk("retire_stall", 64'(stall_o), 64'd0);
`ifdef MISALIGN_CHECK_EN
        chk("retire_m_misalign", 64'(m_misalign), 64'(exp_mis));
`endif
    endtask

    task automatic run_model(
        input logic [3:0]  op,    input logic [63:0] pc,
        input logic [63:0] addr,  input logic [63:0] wdata,
        input logic [63:0] result, input logic [4:0] dst,
        input logic        rw,    input int a_dly, input int d_dly,
        input logic [63:0] rdata);
        int n, off;
        bit mis;
        logic [63:0] er;
        logic erw;
        n   = op_bytes(op);
        off = int'(addr[2:0]);
        mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
        mis = (n != 0) && ((off % n) != 0);
`endif
        if (n == 0) begin
            er  = result;
            erw = rw;
        end else if (mis) begin
            er  = addr;
            erw = 1'b0;
        end else if (op <= 4'h7) begin
            er  = mdl_load(op, addr, rdata);
            erw = rw;
        end else begin
            er  = '0;
            erw = 1'b0;
        end
        run_instr(op, pc, addr, wdata, result, dst, rw, a_dly, d_dly, rdata,
                  er, erw, mdl_size(n),
                  (op >= 4'h8 && n != 0) ? mdl_strobe(n, off) : 8'h00,
                  mdl_sdata(wdata, off), mis);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_pc"}, m_pc, 64'd0);
        chk({tag, "_m_result"}, m_result, 64'd0);
        chk({tag, "_m_dst"}, 64'(m_dst), 64'd0);
        chk({tag, "_m_regwrite"}, 64'(m_regwrite), 64'd0);
        chk({tag, "_stall"}, 64'(stall_o), 64'd0);
        chk({tag, "_dreq_valid"}, 64'(dreq_valid), 64'd0);
        chk({tag, "_dreq_addr"}, dreq_addr, 64'd0);
        chk({tag, "_dreq_size"}, 64'(dreq_size), 64'd0);
        chk({tag, "_dreq_strobe"}, 64'(dreq_strobe), 64'd0);
        chk({tag, "_dreq_data"}, dreq_data, 64'd0);
`ifdef MISALIGN_CHECK_EN
        chk({tag, "_m_misalign"}, 64'(m_misalign), 64'd0);
`endif
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] result;
        logic [4:0]  dst;
        logic        rw;
        int          a_dly;
        int          d_dly;
        logic [63:0] rdata;
        logic [63:0] exp_res;
        logic        exp_rw;
        logic [2:0]  exp_size;
        logic [7:0]  exp_strb;
        logic [63:0] exp_data;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{4'h0, 64'h0, 64'h0, 64'h1234, 5'd5, 1'b1, 0, 0,
                   64'h0, 64'h1234, 1'b1, 3'd0, 8'h00, 64'h0};
        tbl[1] = '{4'h1, 64'h1003, 64'h0, 64'hAAAA, 5'd6, 1'b1, 0, 0,
                   64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80, 1'b1,
                   3'd0, 8'h00, 64'h0};
        tbl[2] = '{4'h6, 64'h2006, 64'h0, 64'h0, 5'd7, 1'b1, 0, 3,
                   64'hBEEF0000_00000000, 64'h00000000_0000BEEF, 1'b1,
                   3'd1, 8'h00, 64'h0};
        tbl[3] = '{4'hA, 64'h104, 64'hDEADBEEF, 64'h77, 5'd8, 1'b1, 2, 0,
                   64'h0, 64'h0, 1'b0, 3'd2, 8'hF0, 64'hDEADBEEF_00000000};
        tbl[4] = '{4'h4, 64'h8, 64'h0, 64'h0, 5'd9, 1'b1, 1, 1,
                   64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 1'b1,
                   3'd3, 8'h00, 64'h0};
        tbl[5] = '{4'h3, 64'h10, 64'h0, 64'h0, 5'd10, 1'b1, 0, 2,
                   64'h00000000_80000001, 64'hFFFFFFFF_80000001, 1'b1,
                   3'd2, 8'h00, 64'h0};
        tbl[6] = '{4'h8, 64'h7, 64'hAB, 64'h0, 5'd11, 1'b1, 0, 0,
                   64'h0, 64'h0, 1'b0, 3'd0, 8'h80, 64'hAB000000_00000000};
        tbl[7] = '{4'hB, 64'h0, 64'h11223344_55667788, 64'h0, 5'd12, 1'b1,
                   1, 0, 64'h0, 64'h0, 1'b0, 3'd3, 8'hFF,
                   64'h11223344_55667788};
        tbl[8] = '{4'hC, 64'h40, 64'h0, 64'h55, 5'd13, 1'b1, 0, 0,
                   64'h0, 64'h55, 1'b1, 3'd0, 8'h00, 64'h0};
        tbl[9] = '{4'h7, 64'h14, 64'h0, 64'h0, 5'd14, 1'b0, 0, 0,
                   64'h80000001_00000000, 64'h00000000_80000001, 1'b0,
                   3'd2, 8'h00, 64'h0};

        reset         = 1'b1;
        e_valid       = 1'b0;
        e_pc          = '0;
        e_mem_op      = '0;
        e_addr        = '0;
        e_wdata       = '0;
        e_result      = '0;
        e_dst         = '0;
        e_regwrite    = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("reset");

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, 64'h8000_0000 + 64'(i * 4), tbl[i].addr,
                      tbl[i].wdata, tbl[i].result, tbl[i].dst, tbl[i].rw,
                      tbl[i].a_dly, tbl[i].d_dly, tbl[i].rdata,
                      tbl[i].exp_res, tbl[i].exp_rw, tbl[i].exp_size,
                      tbl[i].exp_strb, tbl[i].exp_data, 1'b0);
        end

        // m_valid must drop after a single retire pulse.
        @(negedge clk);
        chk("pulse_m_valid", 64'(m_valid), 64'd0);

        // Reset while waiting for data, then a stray data_ok in IDLE.
        e_valid    = 1'b1;
        e_mem_op   = 4'h6;
        e_addr     = 64'h2006;
        e_pc       = 64'h9000;
        e_dst      = 5'd3;
        e_regwrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e_valid       = 1'b0;
        e_mem_op      = 4'h0;
        dresp_addr_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        chk("wd_stall", 64'(stall_o), 64'd1);
        chk("wd_dreq_valid", 64'(dreq_valid), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("midreset");
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hBEEF0000_00000000;
        @(posedge clk);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("stray_m_valid", 64'(m_valid), 64'd0);
        chk("stray_stall", 64'(stall_o), 64'd0);
        chk("stray_dreq_valid", 64'(dreq_valid), 64'd0);
        run_model(4'h0, 64'hA000, 64'h0, 64'h0, 64'hCAFE, 5'd4, 1'b1, 0, 0,
                  64'h0);

`ifdef MISALIGN_CHECK_EN
        run_instr(4'h3, 64'hB000, 64'h3002, 64'h0, 64'h0, 5'd2, 1'b1, 0, 0,
                  64'h0, 64'h3002, 1'b0, 3'd2, 8'h00, 64'h0, 1'b1);
        @(negedge clk);
        chk("mis_pulse", 64'(m_misalign), 64'd0);
`endif

        for (int r = 0; r < 300; r++) begin
            logic [3:0]  op;
            logic [63:0] addr, wd, res, rd;
            op   = 4'($urandom_range(0, 15));
            addr = {$urandom, $urandom};
            wd   = {$urandom, $urandom};
            res  = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            run_model(op, {$urandom, $urandom}, addr, wd, res,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), rd);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rand_pulse_m_valid", 64'(m_valid), 64'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
